rs_inv_arbiter: RTL and testbench

RS_INV_ARBITER -- requirements
Module: rs_inv_arbiter

---
 rtl/cd_dec_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/rs_inv_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rs_inv_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_dec_pkg.sv
// Shared types and constants for the RS decoder GF(256) inverter sharing.
// Optional zero-operand shortcut macro: RS_INV_ARB_ZERO_CHECK_EN.
package cd_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic REQ_C1 = 1'b0;
    localparam logic REQ_C2 = 1'b1;

    localparam int INV_LAT_DEF = 8;

    localparam logic [8:0] GF_POLY = 9'h11D;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector; pointer names the tie winner.
// Part of rs_inv_arbiter (macro RS_INV_ARB_ZERO_CHECK_EN has no effect here).
module rr_arb2
    import cd_dec_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt[REQ_C1] = 1'b1;
            2'b10:   o_gnt[REQ_C2] = 1'b1;
            2'b11:   o_gnt = req_onehot(i_ptr);
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rs_inv_arbiter.sv
// Shares one external gf256_inv between the C1 and C2 decoders.
// Macro RS_INV_ARB_ZERO_CHECK_EN enables the zero-operand shortcut.
module rs_inv_arbiter
    import cd_dec_pkg::*;
#(
    parameter int INV_LAT = INV_LAT_DEF
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [1:0] i_req,
    input  logic [7:0] i_x0,
    input  logic [7:0] i_x1,
    output logic [1:0] o_gnt,
    output logic       o_inv_start,
    output logic [7:0] o_inv_x,
    input  logic [7:0] i_inv_y,
    output logic [7:0] o_y,
    output logic [1:0] o_vld,
    output logic [1:0] o_zero_err,
    output logic       o_busy
);

    localparam int CW = (INV_LAT > 1) ? $clog2(INV_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(INV_LAT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ptr;
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic [1:0]    r_vld;

    logic [1:0]    w_arb_gnt;
    logic          w_win;
    logic [7:0]    w_win_x;
    logic          w_win_zero;
    logic          w_take;
    logic          w_short;
    logic          w_fin;
    logic          w_start;
    logic          w_cnt_load;

    rr_arb2 u_arb (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt)
    );

    assign w_win   = w_arb_gnt[REQ_C2];
    assign w_win_x = w_win ? i_x1 : i_x0;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_short     = 1'b0;
        w_fin       = 1'b0;
        w_start     = 1'b0;
        w_cnt_load  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_req != 2'b00) begin
                    w_take = 1'b1;
                    if (w_win_zero) begin
                        w_short     = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_start     = 1'b1;
                w_cnt_load  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_fin       = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Result and completion are registered on entry to DONE so they
    // are visible during the DONE cycle itself.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_ptr   <= REQ_C1;
            r_owner <= REQ_C1;
            r_cnt   <= '0;
            r_x     <= 8'h00;
            r_y     <= 8'h00;
            r_vld   <= 2'b00;
        end else begin
            if (w_take) begin
                r_owner <= w_win;
                r_x     <= w_win_x;
            end
            if (w_cnt_load) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_fin) begin
                r_y <= i_inv_y;
            end else if (w_short) begin
                r_y <= 8'h00;
            end
            if (w_fin) begin
                r_vld <= req_onehot(r_owner);
            end else if (w_short) begin
                r_vld <= req_onehot(w_win);
            end else begin
                r_vld <= 2'b00;
            end
            if (r_state == DONE) begin
                r_ptr <= ~r_owner;
            end
        end
    end

`ifdef RS_INV_ARB_ZERO_CHECK_EN
    logic [1:0] r_zerr;

    assign w_win_zero = (w_win_x == 8'h00);

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_zerr <= 2'b00;
        end else if (w_short) begin
            r_zerr <= req_onehot(w_win);
        end else begin
            r_zerr <= 2'b00;
        end
    end

    assign o_zero_err = i_res ? 2'b00 : r_zerr;
`else
    assign w_win_zero = 1'b0;
    assign o_zero_err = 2'b00;
`endif

    assign o_gnt       = (w_take && !i_res) ? w_arb_gnt : 2'b00;
    assign o_inv_start = w_start && !i_res;
    assign o_inv_x     = i_res ? 8'h00 : r_x;
    assign o_y         = i_res ? 8'h00 : r_y;
    assign o_vld       = i_res ? 2'b00 : r_vld;
    assign o_busy      = (r_state != IDLE) && !i_res;

endmodule

// File: tb/tb_rs_inv_arbiter.sv
// Bench for rs_inv_arbiter: directed cases plus randomized traffic vs model.
// Expectations follow RS_INV_ARB_ZERO_CHECK_EN when it is defined.
module tb_rs_inv_arbiter;
    import cd_dec_pkg::*;

    localparam int INV_LAT = INV_LAT_DEF;
`ifdef RS_INV_ARB_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_res = 1'b1;
    logic [1:0] i_req = 2'b00;
    logic [7:0] i_x0 = 8'h00;
    logic [7:0] i_x1 = 8'h00;
    logic [7:0] i_inv_y = 8'h00;
    logic [1:0] o_gnt;
    logic       o_inv_start;
    logic [7:0] o_inv_x;
    logic [7:0] o_y;
    logic [1:0] o_vld;
    logic [1:0] o_zero_err;
    logic       o_busy;

    rs_inv_arbiter #(.INV_LAT(INV_LAT)) dut (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_req       (i_req),
        .i_x0        (i_x0),
        .i_x1        (i_x1),
        .o_gnt       (o_gnt),
        .o_inv_start (o_inv_start),
        .o_inv_x     (o_inv_x),
        .i_inv_y     (i_inv_y),
        .o_y         (o_y),
        .o_vld       (o_vld),
        .o_zero_err  (o_zero_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        assert (INV_LAT >= 1)
        else $fatal(1, "FAIL inv_lat: illegal INV_LAT %0d", INV_LAT);
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
        logic [8:0] acc;
        logic [8:0] aa;
        acc = 9'h0;
        aa  = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11D;
        end
        return acc[7:0];
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        for (int b = 1; b < 256; b++) begin
            if (gf_mul(a, 8'(b)) == 8'h01) return 8'(b);
        end
        return 8'h00;
    endfunction

    // Environment model of the external gf256_inv: junk until the
    // result becomes valid INV_LAT cycles after the start pulse.
    int         ecyc = 0;
    int         due = -1;
    logic [7:0] pend_y = 8'h00;
    always @(posedge i_clk) begin
        ecyc <= ecyc + 1;
        if (o_inv_start) begin
            if (INV_LAT == 1) begin
                i_inv_y <= gf_inv(o_inv_x);
            end else begin
                i_inv_y <= 8'($urandom);
                pend_y  <= gf_inv(o_inv_x);
                due     <= ecyc + INV_LAT - 1;
            end
        end else if (ecyc == due) begin
            i_inv_y <= pend_y;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Transaction-level reference state
    bit         m_busy = 0;
    int         m_gnt_c = 0;
    int         m_vld_c = 0;
    int         m_start_c = -1;
    bit         m_own = 0;
    bit         m_zero = 0;
    bit         m_ptr = 0;
    logic [7:0] m_x = 8'h00;
    logic [7:0] m_y = 8'h00;

    // Requester behaviour
    bit         pend[2] = '{0, 0};
    int         glt_n[2] = '{0, 0};
    logic [7:0] rx[2] = '{8'h00, 8'h00};
    int         p_req = 0;
    bit         p_glt = 0;

    int gnt_q[$];
    int gnt_c_q[$];
    int vld_q[$];
    int vld_c_q[$];
    int y_q[$];
    int ez_q[$];
    int n_start = 0;

    function automatic int qv(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [7:0] new_op();
        return ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
    endfunction

    task automatic step(input bit res);
        logic [1:0] eg;
        logic [1:0] ev;
        logic [1:0] ez;
        bit         own;
        bit         eb;
        @(posedge i_clk);
        #1;
        i_res = res;
        i_req = {pend[1] || glt_n[1] != 0, pend[0] || glt_n[0] != 0};
        i_x0  = rx[0];
        i_x1  = rx[1];
        @(negedge i_clk);
        if (res) begin
            m_busy = 0;
            m_ptr = 0;
            m_y = 8'h00;
            m_start_c = -1;
            glt_n = '{0, 0};
            cyc++;
            return;
        end
        if (m_busy && cyc > m_vld_c) m_busy = 0;
        eg = 2'b00;
        if (!m_busy && i_req != 2'b00) begin
            own = (i_req == 2'b11) ? m_ptr : i_req[1];
            eg = 2'b01 << own;
            m_own = own;
            m_x = own ? i_x1 : i_x0;
            m_zero = ZC && (m_x == 8'h00);
            m_gnt_c = cyc;
            m_vld_c = cyc + (m_zero ? 1 : INV_LAT + 2);
            m_start_c = m_zero ? -1 : cyc + 1;
            m_busy = 1;
        end
        eb = m_busy && cyc > m_gnt_c;
        ev = 2'b00;
        ez = 2'b00;
        if (m_busy && cyc == m_vld_c) begin
            ev = 2'b01 << m_own;
            ez = m_zero ? ev : 2'b00;
            m_y = m_zero ? 8'h00 : gf_inv(m_x);
            m_ptr = ~m_own;
        end
        chk("gnt", 32'(o_gnt), 32'(eg));
        chk("inv_start", 32'(o_inv_start), 32'(cyc == m_start_c));
        chk("busy", 32'(o_busy), 32'(eb));
        chk("vld", 32'(o_vld), 32'(ev));
        chk("zero_err", 32'(o_zero_err), 32'(ez));
        chk("y", 32'(o_y), 32'(m_y));
        if (eb) chk("inv_x", 32'(o_inv_x), 32'(m_x));
        if (o_gnt != 0) begin
            gnt_q.push_back(int'(o_gnt));
            gnt_c_q.push_back(cyc);
        end
        if (o_vld != 0) begin
            vld_q.push_back(int'(o_vld));
            vld_c_q.push_back(cyc);
            y_q.push_back(int'(o_y));
            ez_q.push_back(int'(o_zero_err));
        end
        if (o_inv_start) n_start++;
        for (int k = 0; k < 2; k++) begin
            if (glt_n[k] > 0) glt_n[k]--;
            if (o_gnt[k]) begin
                pend[k] = 0;
            end else if (!pend[k] && int'($urandom_range(99)) < p_req) begin
                pend[k] = 1;
                rx[k] = new_op();
            end
            if (p_glt && !pend[k] && glt_n[k] == 0 && m_busy &&
                cyc + 4 < m_vld_c && $urandom_range(9) == 0) begin
                glt_n[k] = int'($urandom_range(2, 1));
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        pend = '{0, 0};
        p_req = 0;
        p_glt = 0;
        step(1'b1);
        gnt_q.delete();
        gnt_c_q.delete();
        vld_q.delete();
        vld_c_q.delete();
        y_q.delete();
        ez_q.delete();
        n_start = 0;
    endtask

    task automatic run_idle(input int lim);
        int n;
        n = 0;
        do begin
            step(1'b0);
            n++;
        end while ((pend[0] || pend[1] || (m_busy && m_vld_c >= cyc))
                   && n < lim);
        chk("run_timeout", 32'(n >= lim), 32'd0);
    endtask

    task automatic run_past_gnt(input int d);
        int n;
        n = 0;
        do begin
            step(1'b0);
            n++;
        end while (!(gnt_c_q.size() > 0 && cyc > gnt_c_q[0] + d) && n < 40);
        chk("gnt_timeout", 32'(n >= 40), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        do_reset();
        step(1'b0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_invx", 32'(o_inv_x), 32'd0);
        chk("rst_y", 32'(o_y), 32'd0);

        // single request from C1
        pend[0] = 1;
        rx[0] = 8'h02;
        run_idle(40);
        chk("t1_gnt", 32'(qv(gnt_q, 0)), 32'd1);
        chk("t1_lat", 32'(qv(vld_c_q, 0) - qv(gnt_c_q, 0)),
            32'(INV_LAT + 2));
        chk("t1_vld", 32'(qv(vld_q, 0)), 32'd1);
        chk("t1_y", 32'(qv(y_q, 0)), 32'h8E);
        chk("t1_nstart", 32'(n_start), 32'd1);

        // simultaneous requests
        do_reset();
        pend = '{1, 1};
        rx[0] = 8'h53;
        rx[1] = 8'h8E;
        run_idle(60);
        chk("t2_gnt0", 32'(qv(gnt_q, 0)), 32'd1);
        chk("t2_gnt1", 32'(qv(gnt_q, 1)), 32'd2);
        chk("t2_gap", 32'(qv(gnt_c_q, 1) - qv(vld_c_q, 0)), 32'd1);
        chk("t2_vld1", 32'(qv(vld_q, 1)), 32'd2);
        chk("t2_y1", 32'(qv(y_q, 1)), 32'h02);

        // fairness under continuous re-request
        do_reset();
        p_req = 100;
        pend = '{1, 1};
        rx[0] = new_op();
        rx[1] = new_op();
        for (int n = 0; n < 200 && gnt_q.size() < 6; n++) step(1'b0);
        p_req = 0;
        pend = '{0, 0};
        run_idle(60);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair_gnt%0d", i), 32'(qv(gnt_q, i)),
                (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("fair_vld%0d", i), 32'(qv(vld_q, i)),
                (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        chk("fair_nvld", 32'(vld_q.size()), 32'd6);

        // reset during WAIT
        do_reset();
        pend[0] = 1;
        rx[0] = 8'h10;
        run_past_gnt(4);
        do_reset();
        step(1'b0);
        chk("mid_busy", 32'(o_busy), 32'd0);
        chk("mid_vld", 32'(o_vld), 32'd0);
        chk("mid_start", 32'(o_inv_start), 32'd0);
        chk("mid_y", 32'(o_y), 32'd0);
        chk("mid_invx", 32'(o_inv_x), 32'd0);
        repeat (15) step(1'b0);
        chk("mid_novld", 32'(vld_q.size()), 32'd0);
        pend[1] = 1;
        rx[1] = 8'h02;
        run_idle(40);
        chk("mid_next_vld", 32'(qv(vld_q, 0)), 32'd2);
        chk("mid_next_y", 32'(qv(y_q, 0)), 32'h8E);

        // zero operand from C2
        do_reset();
        pend[1] = 1;
        rx[1] = 8'h00;
        run_idle(40);
        chk("z_lat", 32'(qv(vld_c_q, 0) - qv(gnt_c_q, 0)),
            ZC ? 32'd1 : 32'(INV_LAT + 2));
        chk("z_vld", 32'(qv(vld_q, 0)), 32'd2);
        chk("z_err", 32'(qv(ez_q, 0)), ZC ? 32'd2 : 32'd0);
        chk("z_y", 32'(qv(y_q, 0)), 32'd0);
        chk("z_nstart", 32'(n_start), ZC ? 32'd0 : 32'd1);

        // request pulse while busy is ignored
        do_reset();
        pend[0] = 1;
        rx[0] = 8'h37;
        run_past_gnt(3);
        glt_n[1] = 2;
        rx[1] = 8'h44;
        run_idle(40);
        chk("ign_ngnt", 32'(gnt_q.size()), 32'd1);
        chk("ign_nvld", 32'(vld_q.size()), 32'd1);

        // randomized traffic with rare resets
        do_reset();
        p_req = 30;
        p_glt = 1;
        for (int n = 0; n < 3000; n++) step($urandom_range(499) == 0);
        p_req = 0;
        p_glt = 0;
        pend = '{0, 0};
        run_idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
